axi4_ar_xlate: RTL and testbench

AXI4_AR_XLATE -- requirements
Module: axi4_ar_xlate

---
 rtl/axi4_ar_xlate.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi4_ar_xlate.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_ar_xlate.sv
// rtl/axi4_ar_xlate.sv - AR channel VA->PA region translation with local DECERR bursts on miss
module axi4_ar_xlate #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int N_ENTRIES      = 4
) (
  input  logic                          axi4_aclk,
  input  logic                          axi4_arst,

  input  logic [AXI_ID_WIDTH-1:0]       s_axi4_arid,
  input  logic [31:0]                   s_axi4_araddr,
  input  logic                          s_axi4_arvalid,
  input  logic [7:0]                    s_axi4_arlen,
  input  logic [2:0]                    s_axi4_arsize,
  input  logic [1:0]                    s_axi4_arburst,
  input  logic                          s_axi4_arlock,
  input  logic [2:0]                    s_axi4_arprot,
  input  logic [3:0]                    s_axi4_arcache,
  input  logic [AXI_USER_WIDTH-1:0]     s_axi4_aruser,
  output logic                          s_axi4_arready,

  output logic [AXI_ID_WIDTH-1:0]       m_axi4_arid,
  output logic [31:0]                   m_axi4_araddr,
  output logic                          m_axi4_arvalid,
  output logic [7:0]                    m_axi4_arlen,
  output logic [2:0]                    m_axi4_arsize,
  output logic [1:0]                    m_axi4_arburst,
  output logic                          m_axi4_arlock,
  output logic [2:0]                    m_axi4_arprot,
  output logic [3:0]                    m_axi4_arcache,
  output logic [AXI_USER_WIDTH-1:0]     m_axi4_aruser,
  input  logic                          m_axi4_arready,

  input  logic [AXI_ID_WIDTH-1:0]       m_axi4_rid,
  input  logic [1:0]                    m_axi4_rresp,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi4_rdata,
  input  logic                          m_axi4_rlast,
  input  logic                          m_axi4_rvalid,
  input  logic [AXI_USER_WIDTH-1:0]     m_axi4_ruser,
  output logic                          m_axi4_rready,

  output logic [AXI_ID_WIDTH-1:0]       s_axi4_rid,
  output logic [1:0]                    s_axi4_rresp,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi4_rdata,
  output logic                          s_axi4_rlast,
  output logic                          s_axi4_rvalid,
  output logic [AXI_USER_WIDTH-1:0]     s_axi4_ruser,
  input  logic                          s_axi4_rready,

  input  logic                          cfg_we,
  input  logic [$clog2(N_ENTRIES)-1:0]  cfg_idx,
  input  logic                          cfg_en,
  input  logic [31:0]                   cfg_va,
  input  logic [31:0]                   cfg_pa,
  input  logic [31:0]                   cfg_mask,
  input  logic                          cfg_bypass,

  output logic                          fault_pulse,
  output logic [31:0]                   fault_addr
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE, ERR} state_t;

  state_t state, state_nxt;

  logic                      rst_d;
  logic                      blocked;

  logic [N_ENTRIES-1:0]      tbl_en;
  logic [31:0]               tbl_va   [N_ENTRIES];
  logic [31:0]               tbl_pa   [N_ENTRIES];
  logic [31:0]               tbl_mask [N_ENTRIES];

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [31:0]               ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_cache;
  logic [AXI_USER_WIDTH-1:0] ar_user;

  logic [N_ENTRIES-1:0]      hit_vec;
  logic [31:0]               pa_vec [N_ENTRIES];
  logic                      lk_hit;
  logic [31:0]               lk_pa;

  logic                      ar_hs;
  logic                      lk_go;
  logic                      fault_q;
  logic [8:0]                beat_cnt;
  logic                      err_go;
  logic                      err_own;
  logic                      err_last;
  logic                      err_hs;
  logic                      r_busy;
  logic                      dn_hs;

  // Outputs stay quiet through reset and the cycle right after it.
  assign blocked  = axi4_arst | rst_d;

  assign ar_hs    = s_axi4_arvalid && (state == IDLE) && !blocked;
  assign lk_go    = cfg_bypass || lk_hit;
  assign err_last = (beat_cnt == {1'b0, ar_len});
  // A DECERR burst may only begin between downstream bursts, then owns R until its last beat.
  assign err_own  = (state == ERR) && (err_go || !r_busy) && !blocked;
  assign err_hs   = err_own && s_axi4_rready;
  assign dn_hs    = m_axi4_rvalid && m_axi4_rready;

  genvar g;
  for (g = 0; g < N_ENTRIES; g++) begin : g_match
    assign hit_vec[g] = tbl_en[g] && ((ar_addr & tbl_mask[g]) == (tbl_va[g] & tbl_mask[g]));
    assign pa_vec[g]  = (tbl_pa[g] & tbl_mask[g]) | (ar_addr & ~tbl_mask[g]);
  end

  // Walk from the top so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit = |hit_vec;
    lk_pa  = ar_addr;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[IDX_W'(i)]) begin
        lk_pa = pa_vec[IDX_W'(i)];
      end
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      tbl_en <= '0;
    end else if (cfg_we) begin
      tbl_en[cfg_idx] <= cfg_en;
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (cfg_we) begin
      tbl_va[cfg_idx]   <= cfg_va;
      tbl_pa[cfg_idx]   <= cfg_pa;
      tbl_mask[cfg_idx] <= cfg_mask;
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ar_hs) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = lk_go ? ISSUE : ERR;
      ISSUE:   if (m_axi4_arready && !blocked) state_nxt = IDLE;
      ERR:     if (err_hs && err_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      rst_d      <= 1'b1;
      ar_id      <= '0;
      ar_addr    <= '0;
      ar_len     <= '0;
      ar_size    <= '0;
      ar_burst   <= '0;
      ar_lock    <= 1'b0;
      ar_prot    <= '0;
      ar_cache   <= '0;
      ar_user    <= '0;
      fault_q    <= 1'b0;
      fault_addr <= '0;
      beat_cnt   <= '0;
      err_go     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      rst_d   <= 1'b0;
      fault_q <= 1'b0;
      if (ar_hs) begin
        ar_id    <= s_axi4_arid;
        ar_addr  <= s_axi4_araddr;
        ar_len   <= s_axi4_arlen;
        ar_size  <= s_axi4_arsize;
        ar_burst <= s_axi4_arburst;
        ar_lock  <= s_axi4_arlock;
        ar_prot  <= s_axi4_arprot;
        ar_cache <= s_axi4_arcache;
        ar_user  <= s_axi4_aruser;
      end
      if (state == LOOKUP) begin
        if (lk_go) begin
          ar_addr <= cfg_bypass ? ar_addr : lk_pa;
        end else begin
          fault_q    <= 1'b1;
          fault_addr <= ar_addr;
        end
      end
      if (err_hs) begin
        beat_cnt <= err_last ? 9'd0 : beat_cnt + 9'd1;
      end
      err_go <= err_own && !(err_hs && err_last);
      if (dn_hs) begin
        r_busy <= !m_axi4_rlast;
      end
    end
  end

  always_comb begin
    s_axi4_arready = 1'b0;
    m_axi4_arvalid = 1'b0;
    m_axi4_arid    = '0;
    m_axi4_araddr  = '0;
    m_axi4_arlen   = '0;
    m_axi4_arsize  = '0;
    m_axi4_arburst = '0;
    m_axi4_arlock  = 1'b0;
    m_axi4_arprot  = '0;
    m_axi4_arcache = '0;
    m_axi4_aruser  = '0;
    s_axi4_rid     = '0;
    s_axi4_rresp   = '0;
    s_axi4_rdata   = '0;
    s_axi4_rlast   = 1'b0;
    s_axi4_rvalid  = 1'b0;
    s_axi4_ruser   = '0;
    m_axi4_rready  = 1'b0;
    fault_pulse    = 1'b0;
    if (!blocked) begin
      s_axi4_arready = (state == IDLE);
      m_axi4_arvalid = (state == ISSUE);
      m_axi4_arid    = ar_id;
      m_axi4_araddr  = ar_addr;
      m_axi4_arlen   = ar_len;
      m_axi4_arsize  = ar_size;
      m_axi4_arburst = ar_burst;
      m_axi4_arlock  = ar_lock;
      m_axi4_arprot  = ar_prot;
      m_axi4_arcache = ar_cache;
      m_axi4_aruser  = ar_user;
      fault_pulse    = fault_q;
      if (err_own) begin
        s_axi4_rvalid = 1'b1;
        s_axi4_rid    = ar_id;
        s_axi4_rresp  = 2'b11;
        s_axi4_ruser  = ar_user;
        s_axi4_rlast  = err_last;
      end else begin
        s_axi4_rvalid = m_axi4_rvalid;
        s_axi4_rid    = m_axi4_rid;
        s_axi4_rresp  = m_axi4_rresp;
        s_axi4_rdata  = m_axi4_rdata;
        s_axi4_rlast  = m_axi4_rlast;
        s_axi4_ruser  = m_axi4_ruser;
        m_axi4_rready = s_axi4_rready;
      end
    end
  end

endmodule

// File: tb/tb_axi4_ar_xlate.sv
// tb/tb_axi4_ar_xlate.sv - directed and randomized bench for axi4_ar_xlate against a region-table model
module tb_axi4_ar_xlate;
  localparam int IW = 4;
  localparam int UW = 4;
  localparam int DW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst;
  logic [IW-1:0] s_arid;    logic [31:0] s_araddr;  logic s_arvalid; logic [7:0] s_arlen;
  logic [2:0]    s_arsize;  logic [1:0]  s_arburst; logic s_arlock;  logic [2:0] s_arprot;
  logic [3:0]    s_arcache; logic [UW-1:0] s_aruser; logic s_arready;
  logic [IW-1:0] m_arid;    logic [31:0] m_araddr;  logic m_arvalid; logic [7:0] m_arlen;
  logic [2:0]    m_arsize;  logic [1:0]  m_arburst; logic m_arlock;  logic [2:0] m_arprot;
  logic [3:0]    m_arcache; logic [UW-1:0] m_aruser; logic m_arready;
  logic [IW-1:0] m_rid;  logic [1:0] m_rresp; logic [DW-1:0] m_rdata; logic m_rlast; logic m_rvalid;
  logic [UW-1:0] m_ruser; logic m_rready;
  logic [IW-1:0] s_rid;  logic [1:0] s_rresp; logic [DW-1:0] s_rdata; logic s_rlast; logic s_rvalid;
  logic [UW-1:0] s_ruser; logic s_rready;
  logic cfg_we; logic [1:0] cfg_idx; logic cfg_en; logic [31:0] cfg_va, cfg_pa, cfg_mask; logic cfg_bypass;
  logic fault_pulse; logic [31:0] fault_addr;

  axi4_ar_xlate #(.AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW), .AXI_DATA_WIDTH(DW), .N_ENTRIES(N)) dut (
    .axi4_aclk(clk), .axi4_arst(arst),
    .s_axi4_arid(s_arid), .s_axi4_araddr(s_araddr), .s_axi4_arvalid(s_arvalid), .s_axi4_arlen(s_arlen),
    .s_axi4_arsize(s_arsize), .s_axi4_arburst(s_arburst), .s_axi4_arlock(s_arlock), .s_axi4_arprot(s_arprot),
    .s_axi4_arcache(s_arcache), .s_axi4_aruser(s_aruser), .s_axi4_arready(s_arready),
    .m_axi4_arid(m_arid), .m_axi4_araddr(m_araddr), .m_axi4_arvalid(m_arvalid), .m_axi4_arlen(m_arlen),
    .m_axi4_arsize(m_arsize), .m_axi4_arburst(m_arburst), .m_axi4_arlock(m_arlock), .m_axi4_arprot(m_arprot),
    .m_axi4_arcache(m_arcache), .m_axi4_aruser(m_aruser), .m_axi4_arready(m_arready),
    .m_axi4_rid(m_rid), .m_axi4_rresp(m_rresp), .m_axi4_rdata(m_rdata), .m_axi4_rlast(m_rlast),
    .m_axi4_rvalid(m_rvalid), .m_axi4_ruser(m_ruser), .m_axi4_rready(m_rready),
    .s_axi4_rid(s_rid), .s_axi4_rresp(s_rresp), .s_axi4_rdata(s_rdata), .s_axi4_rlast(s_rlast),
    .s_axi4_rvalid(s_rvalid), .s_axi4_ruser(s_ruser), .s_axi4_rready(s_rready),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_va(cfg_va), .cfg_pa(cfg_pa),
    .cfg_mask(cfg_mask), .cfg_bypass(cfg_bypass), .fault_pulse(fault_pulse), .fault_addr(fault_addr)
  );

  int tests = 0;
  int fails = 0;

  bit          md_en   [N];
  logic [31:0] md_va   [N];
  logic [31:0] md_pa   [N];
  logic [31:0] md_mask [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Regions are matched in ascending index order; the PA keeps the VA offset below the mask.
  function automatic void model_xlate(input logic [31:0] va, input bit byp, output bit hit, output logic [31:0] pa);
    hit = byp;
    pa  = va;
    if (!byp) begin
      for (int i = 0; i < N; i++) begin
        if (md_en[i] && (((va ^ md_va[i]) & md_mask[i]) == 32'h0)) begin
          hit = 1'b1;
          pa  = (md_pa[i] & md_mask[i]) + (va & ~md_mask[i]);
          break;
        end
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) md_en[i] = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input bit en, input logic [31:0] va, input logic [31:0] pa, input logic [31:0] mask);
    cyc();
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = en; cfg_va = va; cfg_pa = pa; cfg_mask = mask;
    cyc();
    cfg_we = 1'b0;
    md_en[idx] = en; md_va[idx] = va; md_pa[idx] = pa; md_mask[idx] = mask;
  endtask

  // Returns in the LOOKUP cycle, 2 time units after the edge.
  task automatic send_ar(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [UW-1:0] user);
    int n;
    s_arid = id; s_araddr = addr; s_arlen = len; s_aruser = user;
    s_arsize = 3'($urandom); s_arburst = 2'($urandom); s_arlock = 1'($urandom);
    s_arprot = 3'($urandom); s_arcache = 4'($urandom);
    s_arvalid = 1'b1;
    #1;
    n = 0;
    while (s_arready !== 1'b1 && n < 20) begin cyc(); #1; n++; end
    chk("ar_accepted", s_arready, 1);
    cyc();
    s_arvalid = 1'b0;
    #1;
    chk("lookup_quiet", {m_arvalid, s_arready}, 2'b00);
  endtask

  task automatic expect_hit(input logic [IW-1:0] id, input logic [31:0] pa, input logic [7:0] len, input logic [UW-1:0] user, input int stall);
    cyc();
    cfg_we = 1'b0;
    #1;
    chk("issue_arvalid", m_arvalid, 1);
    chk("issue_araddr", m_araddr, pa);
    chk("issue_fields", {m_arid, m_arlen, m_arsize, m_arburst, m_arlock, m_arprot, m_arcache, m_aruser},
        {id, len, s_arsize, s_arburst, s_arlock, s_arprot, s_arcache, user});
    for (int k = 0; k < stall; k++) begin
      cyc(); #1;
      chk("stall_stable", {m_arvalid, s_arready, m_arid, m_arlen, m_araddr}, {1'b1, 1'b0, id, len, pa});
    end
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0;
    #1;
    chk("post_issue_idle", {m_arvalid, s_arready}, 2'b01);
  endtask

  task automatic expect_miss(input logic [IW-1:0] id, input logic [31:0] va, input logic [7:0] len, input logic [UW-1:0] user);
    int pulses, beats, n;
    bit done, arv_seen;
    pulses = 0; beats = 0; n = 0; done = 1'b0; arv_seen = 1'b0;
    while (!done && n < 2000) begin
      cyc();
      cfg_we = 1'b0;
      s_rready = ($urandom_range(0, 3) != 0);
      #1;
      if (fault_pulse) pulses++;
      if (m_arvalid) arv_seen = 1'b1;
      if (s_rvalid && s_rready) begin
        chk("err_beat", {s_rid, s_rresp, s_rdata, s_ruser, s_rlast}, {id, 2'b11, 32'h0, user, beats == int'(len)});
        beats++;
        if (s_rlast) done = 1'b1;
      end
      n++;
    end
    chk("err_beat_count", beats, int'(len) + 1);
    chk("fault_once", pulses, 1);
    chk("fault_addr", fault_addr, va);
    chk("miss_no_arvalid", arv_seen, 0);
    cyc();
    s_rready = 1'b1;
    #1;
    chk("miss_back_idle", {s_arready, s_rvalid}, 2'b10);
  endtask

  task automatic do_ar(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [UW-1:0] user, input bit byp, input int stall);
    bit hit;
    logic [31:0] pa;
    cfg_bypass = byp;
    model_xlate(addr, byp, hit, pa);
    send_ar(id, addr, len, user);
    if (hit) expect_hit(id, pa, len, user, stall);
    else     expect_miss(id, addr, len, user);
    cfg_bypass = 1'b0;
  endtask

  initial begin
    int sel;
    logic [31:0] a;
    arst = 1'b1;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_arlock = 0; s_arprot = 0; s_arcache = 0; s_aruser = 0; m_arready = 0;
    m_rid = 0; m_rresp = 0; m_rdata = 0; m_rlast = 0; m_rvalid = 1'b1; m_ruser = 0; s_rready = 1'b1;
    cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_va = 0; cfg_pa = 0; cfg_mask = 0; cfg_bypass = 0;
    model_reset();

    cyc(); cyc(); #1;
    chk("in_reset_outputs", {s_arready, m_arvalid, s_rvalid, m_rready, fault_pulse, fault_addr}, '0);
    cyc();
    arst = 1'b0;
    #1;
    chk("first_cycle_after_reset", {s_arready, m_arvalid, s_rvalid, m_rready, fault_pulse}, '0);
    cyc();
    m_rvalid = 1'b0;
    #1;
    chk("arready_after_reset", {s_arready, m_rready}, 2'b11);

    cfg_write(0, 1, 32'h4000_0000, 32'h8000_0000, 32'hF000_0000);
    do_ar(4'd1, 32'h4000_1234, 8'd0, 4'd2, 1'b0, 0);
    chk("basic_translation", m_araddr, 32'h8000_1234);

    cfg_write(1, 1, 32'h4000_0000, 32'h9000_0000, 32'hFF00_0000);
    do_ar(4'd2, 32'h4012_3456, 8'd3, 4'd5, 1'b0, 0);
    chk("lowest_index_wins", m_araddr, 32'h8012_3456);

    do_ar(4'd7, 32'h4abc_0000, 8'd15, 4'd9, 1'b0, 5);

    cfg_write(2, 0, 32'h2000_0000, 32'hA000_0000, 32'hF000_0000);
    send_ar(4'd4, 32'h2000_0040, 8'd1, 4'd3);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_en = 1'b1;
    expect_miss(4'd4, 32'h2000_0040, 8'd1, 4'd3);
    md_en[2] = 1'b1;
    do_ar(4'd4, 32'h2000_0040, 8'd0, 4'd3, 1'b0, 1);

    cfg_bypass = 1'b1;
    send_ar(4'd6, 32'hDEAD_BEE0, 8'd2, 4'd1);
    cyc(); cfg_bypass = 1'b0; #1;
    chk("bypass_addr", {m_arvalid, m_araddr}, {1'b1, 32'hDEAD_BEE0});
    arst = 1'b1;
    cyc();
    arst = 1'b0;
    #1;
    chk("reset_in_issue", {m_arvalid, s_arready}, 2'b00);
    model_reset();
    cyc(); #1;
    chk("idle_after_issue_reset", s_arready, 1);

    do_ar(4'd3, 32'h0000_1000, 8'd3, 4'd6, 1'b0, 0);
    do_ar(4'd8, 32'h4000_1234, 8'd0, 4'd0, 1'b0, 0);

    m_rid = 4'd5; m_rresp = 2'b00; m_ruser = 4'd2; s_rready = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'h1111_0001; m_rlast = 1'b0;
    #1; chk("dn_beat1_pass", {s_rvalid, s_rdata, m_rready}, {1'b1, 32'h1111_0001, 1'b1});
    cyc(); m_rdata = 32'h1111_0002; #1;
    chk("dn_beat2_pass", {s_rvalid, s_rdata}, {1'b1, 32'h1111_0002});
    cyc(); m_rvalid = 1'b0;
    send_ar(4'd6, 32'h0000_2000, 8'd1, 4'd7);
    cyc(); #1;
    chk("err_waits_for_burst", s_rvalid, 0);
    cyc(); m_rvalid = 1'b1; m_rdata = 32'h1111_0003; #1;
    chk("dn_beat3_first", {s_rvalid, s_rresp, s_rdata, s_rid, m_rready}, {1'b1, 2'b00, 32'h1111_0003, 4'd5, 1'b1});
    cyc(); m_rdata = 32'h1111_0004; m_rlast = 1'b1; #1;
    chk("dn_beat4_first", {s_rvalid, s_rdata, s_rlast}, {1'b1, 32'h1111_0004, 1'b1});
    cyc(); m_rdata = 32'h2222_0001; #1;
    chk("err_wins_beat0", {s_rvalid, s_rresp, s_rid, s_rlast, m_rready}, {1'b1, 2'b11, 4'd6, 1'b0, 1'b0});
    cyc(); #1;
    chk("err_wins_beat1", {s_rvalid, s_rresp, s_rlast, m_rready}, {1'b1, 2'b11, 1'b1, 1'b0});
    cyc(); #1;
    chk("dn_resumes", {s_rresp, s_rdata, m_rready}, {2'b00, 32'h2222_0001, 1'b1});
    cyc(); m_rvalid = 1'b0; m_rlast = 1'b0;

    do_ar(4'd9, 32'h0300_0000, 8'd255, 4'd4, 1'b0, 0);

    send_ar(4'd2, 32'h0000_3000, 8'd7, 4'd1);
    cyc(); cyc(); cyc();
    arst = 1'b1;
    cyc();
    arst = 1'b0;
    #1;
    chk("err_abandoned_rst", s_rvalid, 0);
    cyc(); #1;
    chk("err_abandoned_idle", {s_rvalid, s_arready}, 2'b01);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, N - 1);
        a = ~(32'hFFFF_FFFF >> (4 * $urandom_range(1, 4)));
        cfg_write(sel, $urandom_range(0, 4) != 0, $urandom & a, $urandom, a);
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, N - 1);
        a = (md_va[sel] & md_mask[sel]) | (a & ~md_mask[sel]);
      end
      do_ar(4'($urandom), a, 8'($urandom_range(0, 5)), 4'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
